// File: rtl/ram_sdp_be_if.sv
// rtl/ram_sdp_be_if.sv - request/response bundle for the simple dual-port byte-enable RAM
// Purpose: groups the write port, read port and status signals of ram_sdp_be.
// Signals:
//   init_busy            zero-fill sweep in progress (RAM drives)
//   wr_en/wr_addr/wr_be/wr_data   write request, per-byte enables (requester drives)
//   rd_en/rd_addr        read request (requester drives)
//   rd_data/rd_valid     read response (RAM drives)
//   par_err/wr_par_flip  parity status and parity-invert hook, only when PARITY_EN is defined
// Modports: master = requester side, slave = RAM side.
interface ram_sdp_be_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4
);
  localparam int NB = DATA_WIDTH / 8;

  logic                  init_busy;
  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [NB-1:0]         wr_be;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  rd_en;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_valid;
`ifdef PARITY_EN
  logic                  par_err;
  logic [NB-1:0]         wr_par_flip;
`endif

  modport master (
`ifdef PARITY_EN
    input  par_err,
    output wr_par_flip,
`endif
    input  init_busy, rd_data, rd_valid,
    output wr_en, wr_addr, wr_be, wr_data, rd_en, rd_addr
  );

  modport slave (
`ifdef PARITY_EN
    output par_err,
    input  wr_par_flip,
`endif
    output init_busy, rd_data, rd_valid,
    input  wr_en, wr_addr, wr_be, wr_data, rd_en, rd_addr
  );
endinterface

// File: rtl/ram_sdp_be.sv
// rtl/ram_sdp_be.sv - simple dual-port RAM with byte enables, zero-fill sweep and 1/2-cycle reads
// Purpose: one write port and one read port usable in the same cycle; memory is swept to zero
//   after every reset so contents are never X. Same-address read/write follows WRITE_FIRST.
// Ports:
//   clk   rising-edge clock
//   rst   asynchronous reset, active-high; restarts the sweep and flushes the read pipeline
//   bus   ram_sdp_be_if.slave (write port, read port, init_busy, rd_valid/rd_data)
// Optional feature macro: PARITY_EN (per-byte even parity, par_err output, wr_par_flip hook).
module ram_sdp_be #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 4,
  parameter int READ_LATENCY = 1,
  parameter int WRITE_FIRST  = 1
) (
  input logic         clk,
  input logic         rst,
  ram_sdp_be_if.slave bus
);
  localparam int NB    = DATA_WIDTH / 8;
  localparam int DEPTH = 1 << ADDR_WIDTH;

  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [0:0]            state;
  logic [ADDR_WIDTH-1:0] cnt;

  logic                  run;
  logic                  wr_fire;
  logic                  rd_fire;
  logic                  collide;
  logic [DATA_WIDTH-1:0] rd_word;

  logic                  s1_valid;
  logic [DATA_WIDTH-1:0] s1_data;
  logic                  rd_valid_q;
  logic [DATA_WIDTH-1:0] rd_data_q;

  assign run     = (state == ST_RUN);
  assign wr_fire = run & bus.wr_en;
  assign rd_fire = run & bus.rd_en;
  // Only a write-first build forwards the incoming write into a same-address read.
  assign collide = wr_fire && (bus.wr_addr == bus.rd_addr) && (WRITE_FIRST != 0);

  assign bus.init_busy = ~run;
  assign bus.rd_valid  = rd_valid_q;
  assign bus.rd_data   = rd_data_q;

  // Read word as seen at the request edge, with enabled lanes forwarded on collision.
  always_comb begin
    rd_word = mem[bus.rd_addr];
    for (int i = 0; i < NB; i++) begin
      if (collide && bus.wr_be[i]) begin
        rd_word[8*i +: 8] = bus.wr_data[8*i +: 8];
      end
    end
  end

  // Storage has no reset; the sweep clears it word by word instead.
  always_ff @(posedge clk) begin
    if (!run) begin
      mem[cnt] <= '0;
    end else if (bus.wr_en) begin
      for (int i = 0; i < NB; i++) begin
        if (bus.wr_be[i]) begin
          mem[bus.wr_addr][8*i +: 8] <= bus.wr_data[8*i +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_INIT;
      cnt        <= '0;
      s1_valid   <= 1'b0;
      s1_data    <= '0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      if (state == ST_INIT) begin
        cnt <= cnt + 1'b1;
        if (&cnt) begin
          state <= ST_RUN;
        end
      end

      if (READ_LATENCY == 1) begin
        rd_valid_q <= rd_fire;
        if (rd_fire) begin
          rd_data_q <= rd_word;
        end
      end else begin
        // Data is captured at the request edge, so a later write cannot alter it.
        s1_valid   <= rd_fire;
        if (rd_fire) begin
          s1_data <= rd_word;
        end
        rd_valid_q <= s1_valid;
        if (s1_valid) begin
          rd_data_q <= s1_data;
        end
      end
    end
  end

`ifdef PARITY_EN
  logic [NB-1:0] par_mem [DEPTH];
  logic [NB-1:0] rd_par;
  logic          perr_c;
  logic          s1_perr;
  logic          par_err_q;

  assign bus.par_err = par_err_q;

  // Stored parity is forwarded per lane exactly like the data, then checked against the word.
  always_comb begin
    rd_par = par_mem[bus.rd_addr];
    perr_c = 1'b0;
    for (int i = 0; i < NB; i++) begin
      if (collide && bus.wr_be[i]) begin
        rd_par[i] = (^bus.wr_data[8*i +: 8]) ^ bus.wr_par_flip[i];
      end
      perr_c = perr_c | ((^rd_word[8*i +: 8]) ^ rd_par[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (!run) begin
      par_mem[cnt] <= '0;
    end else if (bus.wr_en) begin
      for (int i = 0; i < NB; i++) begin
        if (bus.wr_be[i]) begin
          par_mem[bus.wr_addr][i] <= (^bus.wr_data[8*i +: 8]) ^ bus.wr_par_flip[i];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_perr   <= 1'b0;
      par_err_q <= 1'b0;
    end else if (READ_LATENCY == 1) begin
      par_err_q <= rd_fire & perr_c;
    end else begin
      s1_perr   <= rd_fire & perr_c;
      par_err_q <= s1_valid & s1_perr;
    end
  end
`endif

endmodule

// File: tb/tb_ram_sdp_be.sv
// tb/tb_ram_sdp_be.sv - randomized self-checking bench for ram_sdp_be against a word-level model
module tb_ram_sdp_be;
  localparam int DW    = 32;
  localparam int AW    = 4;
  localparam int NB    = DW / 8;
  localparam int DEPTH = 1 << AW;
`ifdef PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          wr_en = 1'b0;
  logic          rd_en = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [AW-1:0] rd_addr = '0;
  logic [NB-1:0] wr_be = '0;
  logic [NB-1:0] wr_par_flip = '0;
  logic [DW-1:0] wr_data = '0;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  ram_sdp_be_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) if_a ();
  ram_sdp_be_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) if_b ();

  assign if_a.wr_en   = wr_en;
  assign if_a.wr_addr = wr_addr;
  assign if_a.wr_be   = wr_be;
  assign if_a.wr_data = wr_data;
  assign if_a.rd_en   = rd_en;
  assign if_a.rd_addr = rd_addr;
  assign if_b.wr_en   = wr_en;
  assign if_b.wr_addr = wr_addr;
  assign if_b.wr_be   = wr_be;
  assign if_b.wr_data = wr_data;
  assign if_b.rd_en   = rd_en;
  assign if_b.rd_addr = rd_addr;
`ifdef PARITY_EN
  assign if_a.wr_par_flip = wr_par_flip;
  assign if_b.wr_par_flip = wr_par_flip;
`endif

  // dut_a: 1-cycle read, write-first.  dut_b: 2-cycle read, read-first.
  ram_sdp_be #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_LATENCY(1), .WRITE_FIRST(1)) dut_a (
    .clk(clk), .rst(rst), .bus(if_a)
  );
  ram_sdp_be #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_LATENCY(2), .WRITE_FIRST(0)) dut_b (
    .clk(clk), .rst(rst), .bus(if_b)
  );

  // Reference model: word array plus per-lane parity-flip flags; a flagged lane is a parity error.
  logic [DW-1:0] m_mem  [DEPTH];
  logic [NB-1:0] m_flip [DEPTH];
  int            busy_left;
  logic          a_v, a_pe, b_v, b_pe, bp_v, bp_pe;
  logic [DW-1:0] a_d, b_d, bp_d;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] lane_mask(input logic [NB-1:0] be);
    logic [DW-1:0] m;
    for (int i = 0; i < NB; i++) m[8*i +: 8] = {8{be[i]}};
    return m;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) begin
      m_mem[i]  = '0;
      m_flip[i] = '0;
    end
    busy_left = DEPTH;
    a_v = 0; a_pe = 0; a_d = '0;
    b_v = 0; b_pe = 0; b_d = '0;
    bp_v = 0; bp_pe = 0; bp_d = '0;
  endtask

  task automatic model_edge();
    logic [DW-1:0] mask;
    logic          hit;
    if (rst) return;
    a_v  = 0;
    a_pe = 0;
    b_v  = bp_v;
    b_pe = bp_v & bp_pe;
    if (bp_v) b_d = bp_d;
    bp_v  = 0;
    bp_pe = 0;
    if (busy_left > 0) begin
      busy_left--;
      return;
    end
    mask = lane_mask(wr_be);
    hit  = wr_en && (wr_addr == rd_addr);
    if (rd_en) begin
      a_v   = 1;
      a_d   = hit ? ((m_mem[rd_addr] & ~mask) | (wr_data & mask)) : m_mem[rd_addr];
      a_pe  = |(hit ? ((m_flip[rd_addr] & ~wr_be) | (wr_par_flip & wr_be)) : m_flip[rd_addr]);
      bp_v  = 1;
      bp_d  = m_mem[rd_addr];
      bp_pe = |m_flip[rd_addr];
    end
    if (wr_en) begin
      m_mem[wr_addr]  = (m_mem[wr_addr] & ~mask) | (wr_data & mask);
      m_flip[wr_addr] = (m_flip[wr_addr] & ~wr_be) | (wr_par_flip & wr_be);
    end
  endtask

  task automatic check_outputs();
    check("a_init_busy", 64'(if_a.init_busy), 64'(busy_left > 0));
    check("b_init_busy", 64'(if_b.init_busy), 64'(busy_left > 0));
    check("a_rd_valid",  64'(if_a.rd_valid),  64'(a_v));
    check("b_rd_valid",  64'(if_b.rd_valid),  64'(b_v));
    check("a_rd_data",   64'(if_a.rd_data),   64'(a_d));
    check("b_rd_data",   64'(if_b.rd_data),   64'(b_d));
`ifdef PARITY_EN
    check("a_par_err",   64'(if_a.par_err),   64'(a_pe));
    check("b_par_err",   64'(if_b.par_err),   64'(b_pe));
`endif
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check_outputs();
  endtask

  task automatic step(input logic we, input logic [AW-1:0] wa, input logic [NB-1:0] be,
                      input logic [DW-1:0] wd, input logic re, input logic [AW-1:0] ra,
                      input logic [NB-1:0] fl);
    wr_en = we; wr_addr = wa; wr_be = be; wr_data = wd;
    rd_en = re; rd_addr = ra;
    wr_par_flip = PAR ? fl : '0;
    tick();
  endtask

  task automatic idle(input int n);
    repeat (n) step(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset(input int hold);
    rst = 1'b1;
    #1;
    model_reset();
    check_outputs();
    repeat (hold) tick();
    rst = 1'b0;
  endtask

  initial begin
    do_reset(2);

    // Sweep length, then every address reads zero.
    idle(DEPTH);
    for (int i = 0; i < DEPTH; i++) step(0, 0, 0, 0, 1, AW'(i), 0);
    idle(2);

    // Byte-enable merge.
    step(1, 3, 4'hF, 32'hDEADBEEF, 0, 0, 0);
    step(1, 3, 4'b0011, 32'h00001122, 0, 0, 0);
    step(0, 0, 0, 0, 1, 3, 0);
    idle(2);

    // Same-address collision: dut_a forwards, dut_b returns stored word.
    step(1, 5, 4'hF, 32'h11111111, 0, 0, 0);
    step(1, 5, 4'hF, 32'hAAAAAAAA, 1, 5, 0);
    step(1, 6, 4'b0101, 32'h55667788, 1, 6, 0);
    idle(2);

    // Back-to-back reads, then a write right after a 2-cycle read request.
    for (int i = 0; i < 4; i++) step(1, AW'(i), 4'hF, 32'h10 + 32'(i), 0, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 1, AW'(i), 0);
    step(1, 0, 4'hF, 32'h99, 0, 0, 0);
    idle(3);

`ifdef PARITY_EN
    step(1, 2, 4'hF, 32'h01020304, 0, 0, 4'b0100);
    step(0, 0, 0, 0, 1, 2, 0);
    idle(2);
    step(1, 2, 4'hF, 32'h01020304, 0, 0, 4'b0000);
    step(0, 0, 0, 0, 1, 2, 0);
    idle(2);
`endif

    // Randomized traffic with frequent same-address collisions.
    for (int n = 0; n < 400; n++) begin
      logic [AW-1:0] wa, ra;
      wa = AW'($urandom);
      ra = ($urandom % 3 == 0) ? wa : AW'($urandom);
      step(1'($urandom), wa, NB'($urandom), $urandom, 1'($urandom), ra,
           ($urandom % 8 == 0) ? NB'($urandom) : '0);
    end
    idle(3);

    // Reset right after a read request, then again partway through the sweep.
    step(1, 3, 4'hF, 32'hDEADBEEF, 0, 0, 0);
    step(0, 0, 0, 0, 1, 3, 0);
    do_reset(1);
    step(1, 3, 4'hF, 32'h12345678, 1, 3, 0);
    idle(6);
    do_reset(1);
    idle(DEPTH);
    step(0, 0, 0, 0, 1, 3, 0);
    idle(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
